rotor_shift_stage: RTL and testbench
====================================

// Module: rotor_shift_stage
// PURPOSE
//   One Enigma rotor stage. Accepts an uppercase ASCII letter over a valid/ready handshake and adds or
//   subtracts the rotor position to form the NTCV (non-truncated character value).
//   Wraps the NTCV back into 'A'..'Z' and registers the result for the next stage.
//   Keeps the rotor position counter (0..25) and emits a carry pulse that steps the next rotor in a chain.
// PARAMETERS
//   INIT_POS  0   rotor position after reset (0..25)
//   NOTCH     25  position from which a step produces carry_out
// PORTS
//   clock      in   1  single clock, rising edge
//   resetn     in   1  asynchronous reset, active-low
//   in_valid   in   1  in_char is valid
//   in_ready   out  1  stage can accept in_char this cycle
//   in_char    in   8  ASCII character, uppercase letter expected (0x41..0x5A)
//   dir        in   1  0: add pos (encrypt, check overflow past 'Z'); 1: subtract pos (decrypt, check underflow below 'A')
//   advance    in   1  rotor may step on this accept; tie 1 for first rotor, else previous stage carry_out
//   load_pos   in   1  synchronous position load strobe
//   load_val   in   5  position to load (0..25)
//   out_valid  out  1  out_char is valid
//   out_ready  in   1  downstream accepts out_char
//   out_char   out  8  shifted, wrapped ASCII letter
//   carry_out  out  1  1-cycle pulse: rotor stepped from NOTCH
//   pos        out  5  current rotor position
// BEHAVIOUR
//   - Reset (resetn=0, async): out_valid=0, out_char=8'h00, carry_out=0, pos=INIT_POS. Applies mid-transfer; a held char is discarded.
//   - in_ready = !out_valid | out_ready (combinational). Accept = in_valid & in_ready.
//   - Latency: 1 cycle, accept at edge N -> out_valid=1 with out_char after edge N.
//   - out_valid/out_char hold stable while out_valid & !out_ready.
//   - out_valid clears after a cycle with out_ready=1 and no accept.
//   - Back-to-back: one accept per cycle when out_ready stays 1.
//   - NTCV (8-bit, no 8-bit wrap possible):
//       dir=0: NTCV = in_char + pos; if NTCV > 0x5A then out = NTCV - 26.
//       dir=1: NTCV = in_char - pos; if NTCV < 0x41 then out = NTCV + 26.
//   - Encoding uses pos as it was before the accepting edge; stepping happens after.
//   - Step: on accept of a letter with advance=1, pos <= (pos==25) ? 0 : pos+1.
//     If the old pos==NOTCH, carry_out=1 for exactly the next cycle, else 0.
//   - load_pos=1: pos <= load_val on the next edge, overriding any step in that cycle, and no carry_out.
//     A char accepted in the same cycle encodes with the pre-load pos.
//     load_val > 25 is ignored; pos is unchanged and the step, if any, still happens.
//   - advance=0: accepted chars encode normally; pos and carry_out are unchanged/0.
// CONFIGURATION
//   NONLETTER_PASS_EN defined: an in_char outside 0x41..0x5A is accepted and passed to out_char unchanged,
//     with out_valid set; there is no step and no carry.
//   NONLETTER_PASS_EN undefined: such an in_char is accepted (consumed) and dropped.
//     out_valid is not set by it, with no step and no carry.
//     A held out_char is unaffected; out_valid still clears if out_ready=1.
// TESTING
//   T1 reset: resetn=0 mid-stream -> out_valid=0, carry_out=0, pos=INIT_POS immediately (async).
//   T2 wrap up: pos=3, dir=0, in 'Y'(0x59) -> out 'B'(0x42) next cycle, pos=4.
//   T3 wrap down: pos=5, dir=1, in 'C'(0x43) -> out 'X'(0x58), pos=6; pos=0 in 'A' -> 'A', pos=1.
//   T4 carry: load_val=24, stream 'A','A','A' with advance=1 -> out 'Y','Z','A'.
//      Expect pos 25,0,1 and one carry_out pulse after the second accept.
//   T5 backpressure: out_ready=0 with 3 chars offered -> only 1 accepted, in_ready=0, out_char stable.
//      Release out_ready -> remaining chars in order, one per cycle.
//   T6 config: in ' '(0x20), pos=7 -> with NONLETTER_PASS_EN out 0x20, pos=7; without it no out_valid, pos=7.

Source files
------------

// File: rtl/rotor_shift_stage_if.sv
// rtl/rotor_shift_stage_if.sv - character stream handshake bundle for one rotor stage
interface rotor_shift_stage_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic       dir;
    logic       advance;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_char;

    modport master (
        output in_valid, in_char, dir, advance, out_ready,
        input  in_ready, out_valid, out_char
    );

    modport slave (
        input  in_valid, in_char, dir, advance, out_ready,
        output in_ready, out_valid, out_char
    );
endinterface

// File: rtl/rotor_shift_stage.sv
// rtl/rotor_shift_stage.sv - Enigma rotor stage: shift/wrap letter by position, step rotor, emit carry
// Optional NONLETTER_PASS_EN: pass non-letters through unchanged instead of dropping them.
module rotor_shift_stage #(
    parameter int unsigned INIT_POS = 0,
    parameter int unsigned NOTCH    = 25
) (
    input  logic                 clock,
    input  logic                 resetn,
    rotor_shift_stage_if.slave   s,
    input  logic                 load_pos,
    input  logic [4:0]           load_val,
    output logic                 carry_out,
    output logic [4:0]           pos
);
    localparam logic [4:0] INIT_POS_L = 5'(INIT_POS);
    localparam logic [4:0] NOTCH_L    = 5'(NOTCH);

    logic       out_valid_q, out_valid_d;
    logic [7:0] out_char_q, out_char_d;
    logic       carry_q, carry_d;
    logic [4:0] pos_q, pos_d;

    logic       in_ready;
    logic       accept;
    logic       is_letter;
    logic       step;
    logic       load_ok;
    logic [7:0] pos8;
    logic [7:0] sum;
    logic [7:0] diff;
    logic [7:0] enc;

    assign in_ready    = !out_valid_q || s.out_ready;
    assign s.in_ready  = in_ready;
    assign s.out_valid = out_valid_q;
    assign s.out_char  = out_char_q;
    assign carry_out   = carry_q;
    assign pos         = pos_q;

    always_comb begin
        accept    = s.in_valid && in_ready;
        is_letter = (s.in_char >= 8'h41) && (s.in_char <= 8'h5A);
        pos8      = {3'b000, pos_q};
        // NTCV stays within 0x28..0x73, so no 8-bit wrap needs handling
        sum       = s.in_char + pos8;
        diff      = s.in_char - pos8;
        if (s.dir)
            enc = (diff < 8'h41) ? diff + 8'd26 : diff;
        else
            enc = (sum > 8'h5A) ? sum - 8'd26 : sum;

        step    = accept && is_letter && s.advance;
        load_ok = load_pos && (load_val <= 5'd25);

        out_valid_d = out_valid_q && !s.out_ready;
        out_char_d  = out_char_q;
        if (accept) begin
            if (is_letter) begin
                out_valid_d = 1'b1;
                out_char_d  = enc;
            end
`ifdef NONLETTER_PASS_EN
            else begin
                out_valid_d = 1'b1;
                out_char_d  = s.in_char;
            end
`endif
        end

        pos_d   = pos_q;
        carry_d = 1'b0;
        if (load_ok) begin
            pos_d = load_val;
        end else if (step) begin
            pos_d   = (pos_q == 5'd25) ? 5'd0 : pos_q + 5'd1;
            carry_d = (pos_q == NOTCH_L);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_char_q  <= 8'h00;
            carry_q     <= 1'b0;
            pos_q       <= INIT_POS_L;
        end else begin
            out_valid_q <= out_valid_d;
            out_char_q  <= out_char_d;
            carry_q     <= carry_d;
            pos_q       <= pos_d;
        end
    end
endmodule

// File: tb/tb_rotor_shift_stage.sv
// tb/tb_rotor_shift_stage.sv - scoreboard bench for rotor_shift_stage with modular-arithmetic reference
module tb_rotor_shift_stage;
    logic       clock = 1'b0;
    logic       resetn;
    logic       load_pos;
    logic [4:0] load_val;
    logic       carry_out;
    logic [4:0] pos;

    int errors = 0;
    int checks = 0;

    rotor_shift_stage_if bus ();

    rotor_shift_stage #(.INIT_POS(0), .NOTCH(25)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .s         (bus),
        .load_pos  (load_pos),
        .load_val  (load_val),
        .carry_out (carry_out),
        .pos       (pos)
    );

    always #5 clock = ~clock;

    logic [7:0] exp_q[$];
    int         m_pos   = 0;
    bit         m_valid = 0;
    bit         m_carry = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] cipher(input logic [7:0] c, input int p, input bit d);
        int idx;
        idx = int'(c) - 65;
        idx = d ? (idx - p + 26) % 26 : (idx + p) % 26;
        return 8'(65 + idx);
    endfunction

    always @(negedge clock) begin
        if (resetn && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {24'h0, bus.out_char}, 32'hFFFF_FFFF);
            end else begin
                chk("out_char", {24'h0, bus.out_char}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // Called at posedge+1; returns after the following posedge+1.
    task automatic cycle(input bit v, input logic [7:0] c, input bit d, input bit adv,
                         input bit rdy, input bit ld, input logic [4:0] lv, output bit acc);
        bit exp_rdy, letter, step, load_ok, nv;
        bus.in_valid  = v;
        bus.in_char   = c;
        bus.dir       = d;
        bus.advance   = adv;
        bus.out_ready = rdy;
        load_pos      = ld;
        load_val      = lv;
        @(negedge clock);
        exp_rdy = !m_valid || rdy;
        chk("in_ready", {31'h0, bus.in_ready}, {31'h0, exp_rdy});
        acc     = v && exp_rdy;
        letter  = (c >= 8'h41) && (c <= 8'h5A);
        step    = acc && letter && adv;
        load_ok = ld && (lv <= 5'd25);
        nv      = m_valid && !rdy;
        if (acc) begin
            if (letter) begin
                exp_q.push_back(cipher(c, m_pos, d));
                nv = 1;
            end
`ifdef NONLETTER_PASS_EN
            else begin
                exp_q.push_back(c);
                nv = 1;
            end
`endif
        end
        m_carry = step && !load_ok && (m_pos == 25);
        if (load_ok) m_pos = int'(lv);
        else if (step) m_pos = (m_pos + 1) % 26;
        m_valid = nv;
        @(posedge clock);
        #1;
        chk("pos", {27'h0, pos}, m_pos);
        chk("carry_out", {31'h0, carry_out}, {31'h0, m_carry});
        chk("out_valid", {31'h0, bus.out_valid}, {31'h0, m_valid});
    endtask

    task automatic idle_load(input logic [4:0] lv);
        bit a;
        cycle(0, 8'h00, 0, 0, 1, 1, lv, a);
    endtask

    task automatic send(input logic [7:0] c, input bit d, input bit adv);
        bit a;
        cycle(1, c, d, adv, 1, 0, 5'd0, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit a;
        int carries;
        logic [7:0] held;
        resetn        = 1'b0;
        bus.in_valid  = 0;
        bus.in_char   = 8'h00;
        bus.dir       = 0;
        bus.advance   = 0;
        bus.out_ready = 1;
        load_pos      = 0;
        load_val      = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_out_valid", {31'h0, bus.out_valid}, 0);
        chk("reset_out_char", {24'h0, bus.out_char}, 0);
        chk("reset_carry", {31'h0, carry_out}, 0);
        chk("reset_pos", {27'h0, pos}, 0);
        resetn = 1'b1;

        // wrap up: pos 3, 'Y' -> 'B'
        idle_load(5'd3);
        send(8'h59, 0, 1);
        chk("t2_char", {24'h0, bus.out_char}, 32'h42);
        // wrap down: pos 5, 'C' -> 'X'; pos 0, 'A' -> 'A'
        idle_load(5'd5);
        send(8'h43, 1, 1);
        chk("t3_char", {24'h0, bus.out_char}, 32'h58);
        idle_load(5'd0);
        send(8'h41, 1, 1);
        chk("t3_char_a", {24'h0, bus.out_char}, 32'h41);

        // carry across the notch
        idle_load(5'd24);
        carries = 0;
        for (int i = 0; i < 3; i++) begin
            send(8'h41, 0, 1);
            if (carry_out) carries++;
        end
        chk("t4_carry_count", carries, 1);

        // load overrides step and suppresses carry; out-of-range load ignored
        idle_load(5'd25);
        cycle(1, 8'h4D, 0, 1, 1, 1, 5'd10, a);
        cycle(1, 8'h4D, 0, 1, 1, 1, 5'd30, a);
        send(8'h4D, 0, 0);

        // backpressure: three chars offered while out_ready=0
        cycle(1, 8'h48, 0, 1, 0, 0, 5'd0, a);
        held = bus.out_char;
        for (int i = 0; i < 2; i++) begin
            cycle(1, 8'h49, 0, 1, 0, 0, 5'd0, a);
            chk("t5_no_accept", {31'h0, a}, 0);
            chk("t5_stable", {24'h0, bus.out_char}, {24'h0, held});
        end
        a = 0;
        for (int i = 0; i < 10 && !a; i++) cycle(1, 8'h49, 0, 1, 1, 0, 5'd0, a);
        chk("t5_accept_2", {31'h0, a}, 1);
        a = 0;
        for (int i = 0; i < 10 && !a; i++) cycle(1, 8'h4A, 0, 1, 1, 0, 5'd0, a);
        chk("t5_accept_3", {31'h0, a}, 1);
        cycle(0, 8'h00, 0, 0, 1, 0, 5'd0, a);

        // non-letter handling
        idle_load(5'd7);
        send(8'h20, 0, 1);
        cycle(0, 8'h00, 0, 0, 1, 0, 5'd0, a);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [7:0] c;
            bit ld;
            c  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                             : 8'($urandom_range(8'h41, 8'h5A));
            ld = ($urandom_range(0, 15) == 0);
            cycle($urandom_range(0, 3) != 0, c, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  ld, 5'($urandom_range(0, 31)), a);
        end

        // asynchronous reset mid-transfer with a held char
        idle_load(5'd9);
        cycle(1, 8'h4B, 0, 1, 0, 0, 5'd0, a);
        #2;
        resetn = 1'b0;
        #1;
        chk("t1_out_valid", {31'h0, bus.out_valid}, 0);
        chk("t1_carry", {31'h0, carry_out}, 0);
        chk("t1_pos", {27'h0, pos}, 0);
        exp_q.delete();
        m_pos   = 0;
        m_valid = 0;
        m_carry = 0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        send(8'h52, 0, 1);
        cycle(0, 8'h00, 0, 0, 1, 0, 5'd0, a);
        cycle(0, 8'h00, 0, 0, 1, 0, 5'd0, a);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
